// File: rtl/step_ctrl.sv
// Single-step / free-run clock-enable controller for the 16-bit RISC core.
// Turns a debounced button pulse into one instruction or a free run, and adds breakpoint, watchdog and retire counter.
module step_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_debounce,
  input  logic             run_mode,
  input  logic             bp_en,
  input  logic [WIDTH-1:0] bp_addr,
  input  logic [WIDTH-1:0] pc,
  input  logic             instr_done,
  output logic             cpu_en,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic             r_s1, r_s2, r_s3;
  logic             r_run1, r_run_s;
  state_t           r_state;
  logic             r_cpu_en, r_halted, r_fault;
  logic [WIDTH-1:0] r_count;
  logic [WD_W-1:0]  r_wdog;

  logic w_step_edge;
  logic w_bp_hit;
  logic w_wd_expire;

  // Synchronizers preset to 1 so a button held across reset release never looks like a new press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_s3    <= 1'b1;
      r_run1  <= 1'b0;
      r_run_s <= 1'b0;
    end else begin
      r_s1    <= step_debounce;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_run1  <= run_mode;
      r_run_s <= r_run1;
    end
  end

  assign w_step_edge = r_s2 & ~r_s3;
  assign w_bp_hit    = bp_en && (pc == bp_addr);
  assign w_wd_expire = (r_wdog == WD_LAST);

  // Output flags are loaded alongside each transition so they always mirror the registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_HALT;
      r_cpu_en <= 1'b0;
      r_halted <= 1'b1;
      r_fault  <= 1'b0;
      r_count  <= '0;
      r_wdog   <= '0;
    end else begin
      case (r_state)
        ST_HALT: begin
          r_wdog <= '0;
          if (w_step_edge) begin
            r_state  <= r_run_s ? ST_RUN : ST_STEP;
            r_cpu_en <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        ST_STEP: begin
          if (instr_done) begin
            r_count  <= r_count + WIDTH'(1);
            r_wdog   <= '0;
            r_state  <= ST_HALT;
            r_cpu_en <= 1'b0;
            r_halted <= 1'b1;
          end else if (w_wd_expire) begin
            r_state  <= ST_FAULT;
            r_cpu_en <= 1'b0;
            r_halted <= 1'b1;
            r_fault  <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        ST_RUN: begin
          if (instr_done) begin
            r_count <= r_count + WIDTH'(1);
            r_wdog  <= '0;
            // run_mode and the breakpoint are only honoured at an instruction boundary.
            if (!r_run_s || w_bp_hit) begin
              r_state  <= ST_HALT;
              r_cpu_en <= 1'b0;
              r_halted <= 1'b1;
            end
          end else if (w_wd_expire) begin
            r_state  <= ST_FAULT;
            r_cpu_en <= 1'b0;
            r_halted <= 1'b1;
            r_fault  <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        default: begin
          r_state  <= ST_FAULT;
          r_cpu_en <= 1'b0;
          r_halted <= 1'b1;
          r_fault  <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_en      = r_cpu_en;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl: per-cycle vector table, directed corner sequences and a random run against a behavioural model.
module tb_step_ctrl;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             step_debounce;
  logic             run_mode;
  logic             bp_en;
  logic [WIDTH-1:0] bp_addr;
  logic [WIDTH-1:0] pc;
  logic             instr_done;
  logic             cpu_en;
  logic             halted;
  logic             fault;
  logic [1:0]       state;
  logic [WIDTH-1:0] instr_count;

  int n_vec = 0;
  int n_err = 0;

  step_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .step_debounce(step_debounce), .run_mode(run_mode),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr_done(instr_done),
    .cpu_en(cpu_en), .halted(halted), .fault(fault), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Reference model: input history windows plus a mode number and an idle-cycle tally.
  bit [2:0]   m_sd;   // step_debounce sampled 1, 2, 3 edges ago
  bit [1:0]   m_rm;   // run_mode sampled 1, 2 edges ago
  int         m_mode; // 0 halted, 1 running, 2 stepping, 3 faulted
  int         m_idle;
  logic [15:0] m_cnt;

  task automatic model_update();
    bit press;
    bit free;
    if (reset) begin
      m_sd = 3'b111; m_rm = 2'b00; m_mode = 0; m_idle = 0; m_cnt = 16'd0;
    end else begin
      press = m_sd[1] && !m_sd[2];
      free  = m_rm[1];
      case (m_mode)
        0: if (press) begin m_mode = free ? 1 : 2; m_idle = 0; end
        1, 2: begin
          if (instr_done) begin
            m_cnt  = m_cnt + 16'd1;
            m_idle = 0;
            if (m_mode == 2 || !free || (bp_en && pc == bp_addr)) m_mode = 0;
          end else begin
            m_idle = m_idle + 1;
            if (m_idle == TIMEOUT) m_mode = 3;
          end
        end
        default: ;
      endcase
      m_sd = {m_sd[1:0], step_debounce};
      m_rm = {m_rm[0], run_mode};
    end
  endtask

  function automatic logic [31:0] pack(input logic en, input logic h, input logic f,
                                       input logic [1:0] st, input logic [15:0] c);
    return {11'd0, en, h, f, st, c};
  endfunction

  function automatic logic [31:0] outs();
    return pack(cpu_en, halted, fault, state, instr_count);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    logic en;
    en = (m_mode == 1 || m_mode == 2);
    check(name, outs(), pack(en, !en, m_mode == 3, 2'(m_mode), m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic pulse(input int w);
    step_debounce = 1'b1;
    repeat (w) tick();
    step_debounce = 1'b0;
  endtask

  task automatic wait_en(input string name);
    int n;
    n = 0;
    while (!cpu_en && n < 10) begin tick(); n++; end
    check(name, 32'(cpu_en), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
  endtask

  typedef struct {
    logic        sd;
    logic        done;
    logic        en;
    logic [1:0]  st;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n;
    int pulse_left;
    // Single step with a 5-cycle button pulse; instr_done on the 4th enabled cycle, then once more while halted.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 16'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd0, 16'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 2'd2, 16'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 2'd2, 16'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 2'd2, 16'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 2'd2, 16'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 2'd0, 16'd1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'd1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 2'd0, 16'd1};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'd1};

    reset = 1'b1; step_debounce = 1'b0; run_mode = 1'b0; bp_en = 1'b0;
    bp_addr = 16'h0010; pc = 16'h0000; instr_done = 1'b0;
    repeat (2) tick();
    check("reset_values", outs(), pack(1'b0, 1'b1, 1'b0, 2'd0, 16'd0));
    reset = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 10; i++) begin
      step_debounce = tbl[i].sd;
      instr_done    = tbl[i].done;
      tick();
      check($sformatf("step_row%0d", i), outs(),
            pack(tbl[i].en, !tbl[i].en, 1'b0, tbl[i].st, tbl[i].cnt));
    end
    instr_done = 1'b0;

    // Watchdog expiry: exactly TIMEOUT enabled cycles, then FAULT that ignores further presses.
    pulse(1);
    wait_en("wd_start");
    n = 0;
    while (cpu_en && n < 20) begin tick(); n++; end
    check("wd_cycles", 32'(n), 32'd8);
    check("wd_fault", outs(), pack(1'b0, 1'b1, 1'b1, 2'd3, 16'd1));
    pulse(3);
    repeat (4) tick();
    check("fault_sticky", outs(), pack(1'b0, 1'b1, 1'b1, 2'd3, 16'd1));
    do_reset();
    check("fault_reset", outs(), pack(1'b0, 1'b1, 1'b0, 2'd0, 16'd0));

    // instr_done landing on the last permitted cycle beats the watchdog.
    pulse(1);
    wait_en("wd2_start");
    repeat (7) tick();
    check("wd_edge_alive", outs(), pack(1'b1, 1'b0, 1'b0, 2'd2, 16'd0));
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    check("wd_done_wins", outs(), pack(1'b0, 1'b1, 1'b0, 2'd0, 16'd1));

    // Free run, instr_done every 3rd cycle, then run_mode dropped mid-instruction.
    run_mode = 1'b1;
    repeat (3) tick();
    pulse(1);
    wait_en("run_start");
    repeat (3) begin
      repeat (2) tick();
      instr_done = 1'b1; tick(); instr_done = 1'b0;
    end
    check("run_count", outs(), pack(1'b1, 1'b0, 1'b0, 2'd1, 16'd4));
    run_mode = 1'b0;
    repeat (2) tick();
    check("run_drop_wait", outs(), pack(1'b1, 1'b0, 1'b0, 2'd1, 16'd4));
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    check("run_drop_halt", outs(), pack(1'b0, 1'b1, 1'b0, 2'd0, 16'd5));

    // Breakpoint at 0x0010, then resume past it without re-triggering.
    bp_en = 1'b1; run_mode = 1'b1;
    repeat (3) tick();
    pulse(1);
    wait_en("bp_start");
    for (int a = 14; a <= 16; a++) begin
      tick();
      pc = 16'(a); instr_done = 1'b1; tick(); instr_done = 1'b0;
      if (a == 15) check("bp_before", outs(), pack(1'b1, 1'b0, 1'b0, 2'd1, 16'd7));
    end
    check("bp_hit", outs(), pack(1'b0, 1'b1, 1'b0, 2'd0, 16'd8));
    pulse(1);
    wait_en("bp_resume");
    tick();
    pc = 16'h0011; instr_done = 1'b1; tick(); instr_done = 1'b0;
    check("bp_no_retrigger", outs(), pack(1'b1, 1'b0, 1'b0, 2'd1, 16'd9));
    bp_en = 1'b0; run_mode = 1'b0;
    repeat (2) tick();
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    check("run_stop", outs(), pack(1'b0, 1'b1, 1'b0, 2'd0, 16'd10));
    check_model("model_sync");

    // Random traffic against the model, with occasional resets to leave FAULT.
    pulse_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pulse_left > 0) begin
        step_debounce = 1'b1; pulse_left--;
      end else begin
        step_debounce = 1'b0;
        if ($urandom_range(0, 9) == 0) pulse_left = int'($urandom_range(1, 6));
      end
      if ($urandom_range(0, 39) == 0) run_mode = ~run_mode;
      if ($urandom_range(0, 49) == 0) bp_en = ~bp_en;
      instr_done = ($urandom_range(0, 3) == 0);
      pc    = ($urandom_range(0, 3) == 0) ? bp_addr : 16'($urandom_range(0, 31));
      reset = ($urandom_range(0, 199) == 0);
      tick();
      check_model($sformatf("random_c%0d", c));
    end
    reset = 1'b0; instr_done = 1'b0; step_debounce = 1'b0; bp_en = 1'b0;

    // Counter wrap: free run retiring every cycle until 0xFFFF rolls over.
    do_reset();
    run_mode = 1'b1;
    repeat (3) tick();
    pulse(1);
    wait_en("wrap_start");
    instr_done = 1'b1;
    n = 0;
    while (instr_count != 16'hFFFF && n < 70000) begin tick(); n++; end
    check("wrap_cycles", 32'(n), 32'd65535);
    check("wrap_ffff", outs(), pack(1'b1, 1'b0, 1'b0, 2'd1, 16'hFFFF));
    tick();
    check("wrap_zero", outs(), pack(1'b1, 1'b0, 1'b0, 2'd1, 16'h0000));

    // Reset during RUN with a pending instr_done and the button held through release.
    step_debounce = 1'b1; reset = 1'b1;
    tick();
    check("reset_mid_run", outs(), pack(1'b0, 1'b1, 1'b0, 2'd0, 16'd0));
    reset = 1'b0; instr_done = 1'b0;
    repeat (3) tick();
    step_debounce = 1'b0;
    repeat (5) tick();
    check("no_spurious_step", outs(), pack(1'b0, 1'b1, 1'b0, 2'd0, 16'd0));
    check_model("model_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
